// File: rtl/tictactoe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tictactoe_pkg: shared types and constants for the 3x3 board/referee  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package tictactoe_pkg;

  localparam int NUM_CELLS  = 9;
  localparam int NUM_LINES  = 8;
  localparam int LINE_IDX_W = $clog2(NUM_LINES);

  localparam logic [3:0]            NOP_ADDR  = 4'b1111;
  localparam logic [3:0]            LAST_CELL = 4'(NUM_CELLS - 1);
  localparam logic [LINE_IDX_W-1:0] LAST_LINE = LINE_IDX_W'(NUM_LINES - 1);

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_X     = 2'b10,
    CELL_O     = 2'b11
  } cellStateType;

  localparam logic [1:0] WIN_P1 = 2'b11;
  localparam logic [1:0] WIN_P2 = 2'b10;
  localparam logic [1:0] TIE    = 2'b01;
  localparam logic [1:0] NO_WIN = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } board_state_t;

  // Scan order: rows, then columns, then the two diagonals.
  localparam logic [3:0] LINE_TABLE [NUM_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

endpackage
`default_nettype wire

// File: rtl/game_board_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | game_board_if: controller <-> board write/status bundle              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface game_board_if;
  import tictactoe_pkg::*;

  logic [3:0]             addr;
  logic [1:0]             cellState;
  logic [2*NUM_CELLS-1:0] gBoard;
  logic                   gameIsDone;
  logic [1:0]             winner;
  logic                   busy;
  logic                   writeRejected;

  modport master (
    output addr, cellState,
    input  gBoard, gameIsDone, winner, busy, writeRejected
  );

  modport slave (
    input  addr, cellState,
    output gBoard, gameIsDone, winner, busy, writeRejected
  );

endinterface
`default_nettype wire

// File: rtl/win_line_check.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | win_line_check: flags three equal, occupied cells and their value    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module win_line_check
  import tictactoe_pkg::*;
(
  input  logic [1:0] i_cell_a,
  input  logic [1:0] i_cell_b,
  input  logic [1:0] i_cell_c,
  output logic       o_hit,
  output logic [1:0] o_value
);

  assign o_hit   = (i_cell_a != CELL_EMPTY) && (i_cell_a == i_cell_b) && (i_cell_b == i_cell_c);
  assign o_value = o_hit ? i_cell_a : NO_WIN;

endmodule
`default_nettype wire

// File: rtl/game_board.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | game_board: 3x3 board memory plus sequential win/tie referee         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module game_board
  import tictactoe_pkg::*;
(
  input  logic          ph1,
  input  logic          ph2,
  input  logic          reset,
  game_board_if.slave   bus
);

  logic [NUM_CELLS-1:0][1:0] r_board, w_board_nxt;
  board_state_t              r_state, w_state_nxt;
  logic [LINE_IDX_W-1:0]     r_line, w_line_nxt;
  logic                      r_done, w_done_nxt;
  logic [1:0]                r_winner, w_winner_nxt;
  logic                      r_rej, w_rej_nxt;

  logic       w_attempt, w_addr_ok, w_accept, w_full, w_hit;
  logic [1:0] w_target, w_hit_val;
  logic       w_unused_ph2;

  // The shared two-phase flop launches on ph1; ph2 carries no extra state here.
  assign w_unused_ph2 = ph2;

  assign w_attempt = (bus.addr != NOP_ADDR) && (bus.cellState != CELL_EMPTY);
  assign w_addr_ok = (bus.addr <= LAST_CELL);
  assign w_target  = w_addr_ok ? r_board[bus.addr] : CELL_EMPTY;
  assign w_accept  = w_attempt && w_addr_ok && (w_target == CELL_EMPTY) && (r_state == ST_IDLE);

  always_comb begin
    w_full = 1'b1;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (r_board[i] == CELL_EMPTY) w_full = 1'b0;
    end
  end

  win_line_check u_line_check (
    .i_cell_a (r_board[LINE_TABLE[r_line][0]]),
    .i_cell_b (r_board[LINE_TABLE[r_line][1]]),
    .i_cell_c (r_board[LINE_TABLE[r_line][2]]),
    .o_hit    (w_hit),
    .o_value  (w_hit_val)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_board_nxt  = r_board;
    w_line_nxt   = r_line;
    w_done_nxt   = r_done;
    w_winner_nxt = r_winner;
    w_rej_nxt    = w_attempt && !w_accept;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_board_nxt[bus.addr] = bus.cellState;
          w_line_nxt            = '0;
          w_state_nxt           = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (w_hit) begin
          w_winner_nxt = w_hit_val;
          w_done_nxt   = 1'b1;
          w_state_nxt  = ST_DONE;
        end else if (r_line == LAST_LINE) begin
          w_line_nxt = '0;
          if (w_full) begin
            w_winner_nxt = TIE;
            w_done_nxt   = 1'b1;
            w_state_nxt  = ST_DONE;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_line_nxt = r_line + LINE_IDX_W'(1);
        end
      end
      ST_DONE: ;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ph1) begin
    if (reset) begin
      r_board  <= '0;
      r_state  <= ST_IDLE;
      r_line   <= '0;
      r_done   <= 1'b0;
      r_winner <= NO_WIN;
      r_rej    <= 1'b0;
    end else begin
      r_board  <= w_board_nxt;
      r_state  <= w_state_nxt;
      r_line   <= w_line_nxt;
      r_done   <= w_done_nxt;
      r_winner <= w_winner_nxt;
      r_rej    <= w_rej_nxt;
    end
  end

  assign bus.gBoard        = r_board;
  assign bus.gameIsDone    = r_done;
  assign bus.winner        = r_winner;
  assign bus.busy          = (r_state == ST_SCAN);
  assign bus.writeRejected = r_rej;

endmodule
`default_nettype wire
